// File: rtl/program_counter.sv
// Program counter for the single-cycle MIPS fetch path: +INC sequencing, stall, branch, jump, jr.
// Optional PC_ALIGN_CHECK_EN adds a registered misaligned flag and word-aligns jr targets.
module program_counter #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int unsigned INC        = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch,
    input  logic [15:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic [31:0] curAddress,
    output logic [31:0] pc_plus4
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic        misaligned
`endif
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned OFF_W  = 16;

    logic [ADDR_W-1:0] branch_disp;
    logic [ADDR_W-1:0] branch_target;
    logic [ADDR_W-1:0] jump_target;
    logic [ADDR_W-1:0] reg_target;
    logic [ADDR_W-1:0] next_address;

    assign pc_plus4 = curAddress + ADDR_W'(INC);

    // Word offset, sign-extended and scaled to bytes; wraps modulo 2^32.
    assign branch_disp   = {{(ADDR_W-OFF_W-2){branch_offset[OFF_W-1]}}, branch_offset, 2'b00};
    assign branch_target = pc_plus4 + branch_disp;
    assign jump_target   = {pc_plus4[31:28], jump_index, 2'b00};

`ifdef PC_ALIGN_CHECK_EN
    logic jr_unaligned;
    logic next_misaligned;

    assign jr_unaligned = (jr_target[1:0] != 2'b00);
    assign reg_target   = {jr_target[31:2], 2'b00};
`else
    assign reg_target   = jr_target;
`endif

    // Next-address selection, highest priority first.
    always_comb begin
        next_address = pc_plus4;
        if (stall) begin
            next_address = curAddress;
        end else if (jr) begin
            next_address = reg_target;
        end else if (jump) begin
            next_address = jump_target;
        end else if (branch) begin
            next_address = branch_target;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            curAddress <= RESET_ADDR;
        end else begin
            curAddress <= next_address;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    // Flag holds across stalls; any other edge reflects the target just loaded.
    always_comb begin
        next_misaligned = 1'b0;
        if (stall) begin
            next_misaligned = misaligned;
        end else if (jr) begin
            next_misaligned = jr_unaligned;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            misaligned <= 1'b0;
        end else begin
            misaligned <= next_misaligned;
        end
    end
`endif

endmodule

// File: tb/tb_program_counter.sv
// Directed-vector bench for program_counter with hand-computed expected addresses.
// Exercises PC_ALIGN_CHECK_EN behaviour when the macro is defined.
module tb_program_counter;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch;
    logic [15:0] branch_offset;
    logic        jump;
    logic [25:0] jump_index;
    logic        jr;
    logic [31:0] jr_target;
    logic [31:0] curAddress;
    logic [31:0] pc_plus4;
`ifdef PC_ALIGN_CHECK_EN
    logic        misaligned;
`endif

    int errors = 0;
    int checks = 0;

    program_counter dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch        (branch),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_index    (jump_index),
        .jr            (jr),
        .jr_target     (jr_target),
        .curAddress    (curAddress),
        .pc_plus4      (pc_plus4)
`ifdef PC_ALIGN_CHECK_EN
        ,
        .misaligned    (misaligned)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctrl();
        stall = 1'b0; branch = 1'b0; jump = 1'b0; jr = 1'b0;
        branch_offset = 16'h0; jump_index = 26'h0; jr_target = 32'h0;
    endtask

    task automatic load_jr(input logic [31:0] target);
        clear_ctrl();
        jr = 1'b1; jr_target = target;
        step();
        clear_ctrl();
    endtask

    initial begin
        reset = 1'b0;
        clear_ctrl();
        #2;
        check("reset_async", curAddress, 32'h0000_0000);

        for (int i = 0; i < 5; i++) begin
            step();
            check("reset_hold_pc", curAddress, 32'h0000_0000);
            check("reset_hold_plus4", pc_plus4, 32'h0000_0004);
        end

        reset = 1'b1;
        for (int i = 0; i < 10; i++) step();
        check("seq_10", curAddress, 32'h0000_0028);

        load_jr(32'h0000_0010);
        check("jr_to_10", curAddress, 32'h0000_0010);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_hold", curAddress, 32'h0000_0010);
        end
        stall = 1'b0;
        step();
        check("stall_release", curAddress, 32'h0000_0014);

        load_jr(32'h0000_0010);
        branch = 1'b1; branch_offset = 16'hFFFE;
        step();
        check("branch_neg", curAddress, 32'h0000_000C);

        load_jr(32'h0000_0010);
        branch = 1'b1; branch_offset = 16'h0003;
        step();
        check("branch_pos", curAddress, 32'h0000_0020);

        load_jr(32'h1000_0000);
        check("jr_load", curAddress, 32'h1000_0000);
        jump = 1'b1; jump_index = 26'h40;
        step();
        check("jump_region", curAddress, 32'h1000_0100);

        clear_ctrl();
        jr = 1'b1; jump = 1'b1; branch = 1'b1;
        jr_target = 32'h2000_0040; jump_index = 26'h3FF_FFFF; branch_offset = 16'h0100;
        step();
        check("prio_jr", curAddress, 32'h2000_0040);

        jr_target = 32'h3000_0000; stall = 1'b1;
        step();
        check("prio_stall", curAddress, 32'h2000_0040);

        clear_ctrl();
        jump = 1'b1; branch = 1'b1; jump_index = 26'h00_0010; branch_offset = 16'h0040;
        step();
        check("prio_jump", curAddress, 32'h2000_0040);

        load_jr(32'hFFFF_FFFC);
        check("wrap_plus4", pc_plus4, 32'h0000_0000);
        step();
        check("wrap_seq", curAddress, 32'h0000_0000);

        branch = 1'b1; branch_offset = 16'hFFFE;
        step();
        check("branch_borrow", curAddress, 32'hFFFF_FFFC);

        load_jr(32'h0000_0040);
        check("pre_reset", curAddress, 32'h0000_0040);
        branch = 1'b1; branch_offset = 16'h0010;
        #2;
        reset = 1'b0;
        #1;
        check("reset_mid", curAddress, 32'h0000_0000);
        step();
        check("reset_discard", curAddress, 32'h0000_0000);
        clear_ctrl();
        reset = 1'b1;
        step();
        check("reset_resume", curAddress, 32'h0000_0004);

        load_jr(32'h0000_0102);
`ifdef PC_ALIGN_CHECK_EN
        check("align_pc", curAddress, 32'h0000_0100);
        check("align_flag_set", 32'(misaligned), 32'h1);
        step();
        check("align_seq", curAddress, 32'h0000_0104);
        check("align_flag_clr", 32'(misaligned), 32'h0);
`else
        check("jr_unaligned", curAddress, 32'h0000_0102);
        step();
        check("unaligned_seq", curAddress, 32'h0000_0106);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
